// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO pair: WIDTH-cycle shift-add
// multiply and restoring divide. Define MDU_SINGLE_CYCLE_MULT_EN for a one-cycle registered mult.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [1:0]         op_q, op_d;
  logic               neg_p_q, neg_p_d, neg_r_q, neg_r_d, div0_q, div0_d, done_q, done_d;

  logic               sgn, div_ge;
  logic [WIDTH-1:0]   a_abs, b_abs, quo, rem;
  logic [WIDTH:0]     mul_sum, rem_sh;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    sgn      = ~op[0];
    a_abs    = (sgn && A[WIDTH-1]) ? -A : A;
    b_abs    = (sgn && B[WIDTH-1]) ? -B : B;
    // Multiply: add multiplicand into the upper half, then shift the pair right.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
    // Divide: bring down the next dividend bit and try subtracting the divisor.
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
    div_diff = {1'b0, rem_sh} - {2'b00, b_q};
    div_ge   = ~div_diff[WIDTH+1];
    prod     = neg_p_q ? -acc_q : acc_q;
    quo      = acc_q[WIDTH-1:0];
    rem      = acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    neg_p_d = neg_p_q;
    neg_r_d = neg_r_q;
    div0_d  = div0_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (hi_wr) hi_d = wdata;
        if (lo_wr) lo_d = wdata;
        if (start) begin
          op_d    = op;
          a_d     = a_abs;
          b_d     = b_abs;
          neg_p_d = sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
          neg_r_d = sgn & A[WIDTH-1];
          div0_d  = (B == '0);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
`ifdef MDU_SINGLE_CYCLE_MULT_EN
          if (!op[1]) begin
            acc_d   = {{WIDTH{1'b0}}, a_abs} * {{WIDTH{1'b0}}, b_abs};
            state_d = FINISH;
          end
`endif
        end
      end
      CALC: begin
        if (op_q[1]) begin
          acc_d = {div_ge ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge};
          a_d   = a_q << 1;
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          b_d   = b_q >> 1;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) state_d = FINISH;
      end
      FINISH: begin
        if (op_q[1]) begin
          // Divide by zero bypasses sign fix-up so lo stays all ones.
          lo_d = div0_q ? '1 : (neg_p_q ? -quo : quo);
          hi_d = neg_r_q ? -rem : rem;
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      neg_p_q <= 1'b0;
      neg_r_q <= 1'b0;
      div0_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      neg_p_q <= neg_p_d;
      neg_r_q <= neg_r_d;
      div0_q  <= div0_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

- Iterative, parametrised multiply/divide unit that owns the HI/LO register pair.
- Successor to the combinational mult/div path in the ALU. It removes the single-cycle 64-bit multiplier and divider from the critical path by replacing them with a WIDTH-cycle shift-add / restoring-divide engine.
- Sits beside the ALU in the execute stage. The control unit issues an operation, stalls on `busy`, and reads `hi`/`lo` for mfhi/mflo.

## Interface
- `WIDTH`, 32: operand width; `hi`/`lo` are each WIDTH bits.
- `clk` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: issue strobe, sampled on the rising edge.
- `op` input 2: 0 = mult, 1 = multu, 2 = div, 3 = divu.
- `A` input WIDTH: multiplicand / dividend (rs).
- `B` input WIDTH: multiplier / divisor (rt).
- `hi_wr` input 1: mthi strobe.
- `lo_wr` input 1: mtlo strobe.
- `wdata` input WIDTH: data for mthi/mtlo.
- `busy` output 1: operation in progress.
- `done` output 1: one-cycle completion pulse.
- `hi` output WIDTH: HI register (product high half / remainder).
- `lo` output WIDTH: LO register (product low half / quotient).

## Operation
- **States:**
  - IDLE: on `start`, go to CALC.
  - CALC: runs WIDTH iterations, then goes to FINISH.
  - FINISH: writes HI/LO, then returns to IDLE.
- **Start (IDLE only):**
  - Latch `op`.
  - For signed ops, latch |A| and |B| and the result signs: product sign = sign(A) xor sign(B); remainder sign = sign(A).
  - Clear the 2·WIDTH-bit accumulator and the iteration counter.
- **CALC, one iteration per cycle:**
  - Multiply: shift-add, one multiplier bit per cycle.
  - Divide: restoring, one quotient bit per cycle.
  - The counter counts 0..WIDTH-1.
- **FINISH:**
  - Apply sign correction.
  - Write HI/LO.
  - Pulse `done`.
- **Arithmetic rules:**
  - Multiply gives the full 2·WIDTH-bit result: hi = upper half, lo = lower half.
  - Divide: lo = quotient truncated toward zero; hi = remainder, which takes the sign of the dividend.
- **Divide by zero:** lo = all ones, hi = A, for both div and divu. Completes with normal latency.
- **Signed overflow** (div of most-negative value by -1): lo = most-negative value, hi = 0.
- **Issue rules:**
  - `start` while busy: ignored, no effect on the running operation.
  - `hi_wr`/`lo_wr` in IDLE: the register is loaded from `wdata` at the edge.
  - `hi_wr`/`lo_wr` while busy: ignored. The controller must stall mthi/mtlo until `busy` is low.
  - `start` together with `hi_wr`/`lo_wr` in IDLE: the write is applied, then overwritten at FINISH.
- **Operand stability:** A, B and `op` are sampled only at the start edge and may change afterwards.

## Timing
- **Reset values:**
  - `hi` = 0, `lo` = 0.
  - `busy` = 0, `done` = 0.
  - State = IDLE, counter = 0.
- **Reset mid-operation:** aborts immediately and clears HI/LO. No `done` is produced.
- **Latency**, with `start` sampled at edge E0:
  - `busy` = 1 from E0 through E(WIDTH+1).
  - After E(WIDTH+1): `hi`/`lo` hold the result, `done` = 1 for exactly one cycle, `busy` = 0.
  - A new `start` is accepted in the same cycle that `done` is high.
- **Output stability:** `hi`/`lo` hold their previous values throughout CALC; no intermediate values are visible.
- **Throughput:** one operation per WIDTH+2 cycles.

## Configuration
- **Macro:** `MDU_SINGLE_CYCLE_MULT_EN`.
- **When defined:**
  - mult/multu use a registered full-width `*`.
  - `busy` = 1 for the single cycle after E0.
  - Result and `done` are valid after E1.
  - div/divu are unchanged (iterative).
- **When undefined:** all four ops are iterative with the latency above. Interface is identical in both builds.

## Test plan
All scenarios use WIDTH = 32.
- **mult:** A = 0xFFFFFFFE, B = 3 → hi = 0xFFFFFFFF, lo = 0xFFFFFFFA. `done` after E33 (after E1 with the macro defined); `busy` low in the same cycle.
- **multu:** A = 0xFFFFFFFE, B = 3 → hi = 0x00000002, lo = 0xFFFFFFFA.
- **div:** A = 0xFFFFFFF9 (-7), B = 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- **Special divides:**
  - divu A = 0x1234, B = 0 → lo = 0xFFFFFFFF, hi = 0x1234.
  - div A = 0x80000000, B = 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- **Busy rules:**
  - `start` with new operands and `hi_wr` = 1 (wdata = 0xDEAD) at E5 of a running divu 100 / 7 → both ignored; result lo = 14, hi = 2.
  - mthi 0xDEAD in IDLE → hi = 0xDEAD.
- **Reset mid-op:** assert `reset` at E10 of a mult → `busy`, `done`, `hi`, `lo` go to 0 immediately. A fresh multu 5 × 6 then yields lo = 30, hi = 0.
